// File: rtl/coef_pkg.sv
// ---------------------------------------------------------------------------
// coef_pkg
// Shared definitions for the coefficient loader:
//   - COEFW_DEF : default coefficient word width written to the RAM
//   - AW_DEF    : default coefficient write-address width
//   - SDATA_W   : width of the signed source word on the input stream
//   - state_t   : loader FSM state encoding
// ---------------------------------------------------------------------------
package coef_pkg;

    localparam int COEFW_DEF = 18;
    localparam int AW_DEF    = 7;
    localparam int SDATA_W   = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage : coef_pkg

// File: rtl/coef_loader_if.sv
// ---------------------------------------------------------------------------
// coef_loader_if
// Bundles the coefficient loader's handshake and RAM-write signals.
//   start, s_data, s_valid, s_last : driven by the frame source (master)
//   s_ready                        : stream back-pressure from the loader
//   coef_write, coef_write_addr,
//   coef_write_en                  : coefficient RAM write port
//   busy, done, err_short, err_long: frame status
// Modports:
//   master : the side that sources frames and observes the loader
//   slave  : the loader side
// ---------------------------------------------------------------------------
interface coef_loader_if
    import coef_pkg::*;
#(
    parameter int COEFW = COEFW_DEF,
    parameter int AW    = AW_DEF
);

    logic               start;
    logic [SDATA_W-1:0] s_data;
    logic               s_valid;
    logic               s_last;
    logic               s_ready;
    logic [COEFW-1:0]   coef_write;
    logic [AW-1:0]      coef_write_addr;
    logic               coef_write_en;
    logic               busy;
    logic               done;
    logic               err_short;
    logic               err_long;

    modport master (
        output start, s_data, s_valid, s_last,
        input  s_ready, coef_write, coef_write_addr, coef_write_en,
        input  busy, done, err_short, err_long
    );

    modport slave (
        input  start, s_data, s_valid, s_last,
        output s_ready, coef_write, coef_write_addr, coef_write_en,
        output busy, done, err_short, err_long
    );

endinterface : coef_loader_if

// File: rtl/coef_sat.sv
// ---------------------------------------------------------------------------
// coef_sat
// Combinational word-width conversion from the IN_W-bit signed source word
// to the OUT_W-bit signed coefficient.
//   SATURATE = 0 : plain truncation, dout_o = din_i[OUT_W-1:0]
//   SATURATE = 1 : clamp to [-2**(OUT_W-1), 2**(OUT_W-1)-1]
// Ports:
//   din_i  : signed source word (IN_W bits)
//   dout_o : converted signed coefficient (OUT_W bits)
// Only the selected branch is elaborated, so the truncating build carries no
// comparison logic at all.
// ---------------------------------------------------------------------------
module coef_sat
    import coef_pkg::*;
#(
    parameter int IN_W     = SDATA_W,
    parameter int OUT_W    = COEFW_DEF,
    parameter bit SATURATE = 1'b0
) (
    input  logic [IN_W-1:0]  din_i,
    output logic [OUT_W-1:0] dout_o
);

    generate
        if (SATURATE) begin : g_sat
            // The value fits in OUT_W signed bits exactly when every bit from
            // the output sign position upward is a copy of the input sign.
            logic [IN_W-OUT_W:0] top_bits;
            logic                fits;

            assign top_bits = din_i[IN_W-1:OUT_W-1];
            assign fits     = (top_bits == '0) || (top_bits == '1);

            always_comb begin
                if (fits) begin
                    dout_o = din_i[OUT_W-1:0];
                end else if (din_i[IN_W-1]) begin
                    dout_o = {1'b1, {(OUT_W-1){1'b0}}};
                end else begin
                    dout_o = {1'b0, {(OUT_W-1){1'b1}}};
                end
            end
        end else begin : g_trunc
            assign dout_o = din_i[OUT_W-1:0];

            // Upper source bits are intentionally dropped in this build.
            if (OUT_W < IN_W) begin : g_drop
                logic unused_hi;
                assign unused_hi = ^din_i[IN_W-1:OUT_W];
            end
        end
    endgenerate

endmodule : coef_sat

// File: rtl/coef_loader.sv
// ---------------------------------------------------------------------------
// coef_loader
// Loads one frame of coefficients from a valid/ready stream into a
// coefficient RAM write port.  A single-cycle start in IDLE opens a frame;
// every accepted word is converted and written one cycle later at the next
// sequential address.  Frames that end early set err_short; frames that run
// past NCOEF words set err_long and the surplus words are drained unwritten
// until s_last.  done pulses for the single DONE cycle.
//
// Parameters:
//   COEFW : coefficient word width
//   AW    : RAM write-address width
//   NCOEF : expected coefficients per frame (1 .. 2**AW)
// Ports:
//   clkw            : clock, all logic on the rising edge
//   rst             : synchronous active-high reset
//   start           : begin a frame (honoured in IDLE only)
//   s_data          : signed 32-bit source word
//   s_valid         : s_data valid
//   s_last          : final word of the frame
//   s_ready         : loader accepts a word this cycle (LOAD / DRAIN)
//   coef_write      : converted coefficient to the RAM
//   coef_write_addr : RAM write address
//   coef_write_en   : RAM write strobe
//   busy            : frame in progress (LOAD / DRAIN / DONE)
//   done            : one-cycle end-of-frame pulse
//   err_short       : sticky, s_last seen before NCOEF words
//   err_long        : sticky, NCOEF words seen without s_last
// Build option:
//   COEF_LOADER_SATURATE_EN : when defined, words are saturated to the signed
//                             COEFW range instead of truncated.
// ---------------------------------------------------------------------------
module coef_loader
    import coef_pkg::*;
#(
    parameter int COEFW = COEFW_DEF,
    parameter int AW    = AW_DEF,
    parameter int NCOEF = 2**AW
) (
    input  logic               clkw,
    input  logic               rst,
    input  logic               start,
    input  logic [SDATA_W-1:0] s_data,
    input  logic               s_valid,
    input  logic               s_last,
    output logic               s_ready,
    output logic [COEFW-1:0]   coef_write,
    output logic [AW-1:0]      coef_write_addr,
    output logic               coef_write_en,
    output logic               busy,
    output logic               done,
    output logic               err_short,
    output logic               err_long
);

`ifdef COEF_LOADER_SATURATE_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    localparam logic [AW-1:0] LAST_IDX = AW'(NCOEF - 1);

    state_t           state_q,     state_d;
    logic [AW-1:0]    cnt_q,       cnt_d;
    logic [COEFW-1:0] wr_data_q,   wr_data_d;
    logic [AW-1:0]    wr_addr_q,   wr_addr_d;
    logic             wr_en_q,     wr_en_d;
    logic             err_short_q, err_short_d;
    logic             err_long_q,  err_long_d;
    logic [COEFW-1:0] conv_data;
    logic             at_last_idx;

    coef_sat #(
        .IN_W     (SDATA_W),
        .OUT_W    (COEFW),
        .SATURATE (SAT_EN)
    ) u_sat (
        .din_i  (s_data),
        .dout_o (conv_data)
    );

    assign at_last_idx = (cnt_q == LAST_IDX);

    always_ff @(posedge clkw) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            wr_data_q   <= '0;
            wr_addr_q   <= '0;
            wr_en_q     <= 1'b0;
            err_short_q <= 1'b0;
            err_long_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_data_q   <= wr_data_d;
            wr_addr_q   <= wr_addr_d;
            wr_en_q     <= wr_en_d;
            err_short_q <= err_short_d;
            err_long_q  <= err_long_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_data_d   = wr_data_q;
        wr_addr_d   = wr_addr_q;
        wr_en_d     = 1'b0;
        err_short_d = err_short_q;
        err_long_d  = err_long_q;
        s_ready     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_LOAD;
                    cnt_d       = '0;
                    err_short_d = 1'b0;
                    err_long_d  = 1'b0;
                end
            end

            ST_LOAD: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    wr_en_d   = 1'b1;
                    wr_data_d = conv_data;
                    wr_addr_d = cnt_q;
                    // Hold at the last index so the counter can never wrap
                    // (with NCOEF == 2**AW the increment would roll to 0).
                    if (!at_last_idx) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (s_last) begin
                        state_d = ST_DONE;
                        if (!at_last_idx) begin
                            err_short_d = 1'b1;
                        end
                    end else if (at_last_idx) begin
                        state_d    = ST_DRAIN;
                        err_long_d = 1'b1;
                    end
                end
            end

            ST_DRAIN: begin
                s_ready = 1'b1;
                if (s_valid && s_last) begin
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign coef_write      = wr_data_q;
    assign coef_write_addr = wr_addr_q;
    assign coef_write_en   = wr_en_q;
    assign busy            = (state_q != ST_IDLE);
    assign done            = (state_q == ST_DONE);
    assign err_short       = err_short_q;
    assign err_long        = err_long_q;

endmodule : coef_loader
